// File: rtl/beat_packer.sv
// Width upsizer: packs RATIO consecutive WIDTH-bit beats into one registered wide word.
// A beat flagged in_last closes the word early; out_keep marks the lanes that hold real beats.
module beat_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_rdy,
  output logic                   out_val,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last,
  input  logic                   out_rdy
);

  localparam int CW = $clog2(RATIO);
  localparam int AW = WIDTH * (RATIO - 1);
  localparam int OW = WIDTH * RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             val_q, val_d;
  logic [OW-1:0]    data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             last_q, last_d;

  logic             accept_s;
  logic             complete_s;
  logic [OW-1:0]    acc_ext_s;
  logic [OW-1:0]    word_s;
  logic [RATIO-1:0] keep_s;

  // A stalled output word blocks every beat, completing or not.
  assign in_rdy     = ~val_q | out_rdy;
  assign accept_s   = in_val & in_rdy;
  assign complete_s = accept_s & ((cnt_q == LAST_LANE) | in_last);
  assign acc_ext_s  = {{WIDTH{1'b0}}, acc_q};

  // Candidate output word: stored lanes below cnt, the incoming beat at cnt, zeros above.
  always_comb begin
    word_s = '0;
    keep_s = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CW'(k) < cnt_q) begin
        word_s[k*WIDTH +: WIDTH] = acc_ext_s[k*WIDTH +: WIDTH];
        keep_s[k]                = 1'b1;
      end else if (CW'(k) == cnt_q) begin
        word_s[k*WIDTH +: WIDTH] = in_data;
        keep_s[k]                = 1'b1;
      end else begin
        word_s[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        keep_s[k]                = 1'b0;
      end
    end
  end

  // Next-state for accumulator, lane count and output register.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    val_d  = val_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    if (complete_s) begin
      acc_d  = '0;
      cnt_d  = '0;
      val_d  = 1'b1;
      data_d = word_s;
      keep_d = keep_s;
      last_d = in_last;
    end else begin
      if (accept_s) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CW'(k) == cnt_q) begin
            acc_d[k*WIDTH +: WIDTH] = in_data;
          end else begin
            acc_d[k*WIDTH +: WIDTH] = acc_q[k*WIDTH +: WIDTH];
          end
        end
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      val_d = val_q & ~out_rdy;
    end
  end

  // State registers; reset discards any partial accumulation and pending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      val_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  assign out_val  = val_q;
  assign out_data = data_q;
  assign out_keep = keep_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_beat_packer.sv
// Scoreboard bench for beat_packer (WIDTH=8, RATIO=4): expected words are queued as beats
// are driven and compared against words captured on the output handshake.
module tb_beat_packer;

  localparam int W = 8;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_val;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_rdy;
  logic           out_val;
  logic [W*R-1:0] out_data;
  logic [R-1:0]   out_keep;
  logic           out_last;
  logic           out_rdy;

  typedef struct packed {
    logic [W*R-1:0] data;
    logic [R-1:0]   keep;
    logic           last;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  beat_packer #(.WIDTH(W), .RATIO(R)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_data (in_data),
    .in_last (in_last),
    .in_rdy  (in_rdy),
    .out_val (out_val),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_last(out_last),
    .out_rdy (out_rdy)
  );

  always #5 clk = ~clk;

  // Capture every word that will be taken at the coming rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_val === 1'b1 && out_rdy === 1'b1)
      got_q.push_back({out_data, out_keep, out_last});
  end

  task automatic send_beat(input logic [W-1:0] d, input logic l, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    in_val  = 1'b1;
    in_data = d;
    in_last = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (in_rdy === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat timeout: beat %h never accepted within 100 cycles", d);
    end
  endtask

  task automatic test_reset();
    in_val = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_val, out_data, out_keep, out_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got val=%b data=%h keep=%b last=%b, want all zero",
               out_val, out_data, out_keep, out_last);
    end
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    int c;
    word_t e, g;
    out_rdy = 1'b1;
    send_beat(8'h11, 1'b0, c);
    send_beat(8'h22, 1'b0, c);
    send_beat(8'h33, 1'b0, c);
    send_beat(8'h44, 1'b0, c);
    exp_q.push_back({32'h44332211, 4'b1111, 1'b0});
    n_checks++;
    if (out_val !== 1'b1 || out_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL full_word_latency: got val=%b data=%h want val=1 data=44332211", out_val, out_data);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL full_word_single_cycle: got out_val=%b want 0", out_val);
    end
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_word_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL full_word: got %h/%b/%b want %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_early_last();
    int c;
    word_t e, g;
    out_rdy = 1'b1;
    send_beat(8'hAA, 1'b0, c);
    send_beat(8'hBB, 1'b1, c);
    exp_q.push_back({32'h0000BBAA, 4'b0011, 1'b1});
    send_beat(8'hCC, 1'b0, c);
    send_beat(8'hDD, 1'b0, c);
    send_beat(8'hEE, 1'b0, c);
    send_beat(8'hFF, 1'b0, c);
    exp_q.push_back({32'hFFEEDDCC, 4'b1111, 1'b0});
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL early_last_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL early_last: got %h/%b/%b want %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    int c;
    word_t e, g;
    out_rdy = 1'b0;
    send_beat(8'h01, 1'b0, c);
    send_beat(8'h02, 1'b0, c);
    send_beat(8'h03, 1'b0, c);
    send_beat(8'h04, 1'b0, c);
    exp_q.push_back({32'h04030201, 4'b1111, 1'b0});
    in_val = 1'b1; in_data = 8'h05; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_val !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'b1111 ||
          out_last !== 1'b0 || in_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold: got val=%b data=%h keep=%b last=%b in_rdy=%b want 1/04030201/1111/0/0",
                 out_val, out_data, out_keep, out_last, in_rdy);
      end
      @(posedge clk);
      #1;
    end
    out_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got in_rdy=%b want 1", in_rdy);
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    send_beat(8'h06, 1'b0, c);
    send_beat(8'h07, 1'b0, c);
    send_beat(8'h08, 1'b0, c);
    exp_q.push_back({32'h08070605, 4'b1111, 1'b0});
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL backpressure_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL backpressure: got %h/%b/%b want %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_streaming();
    int c;
    int total;
    logic [W*R-1:0] w;
    word_t e, g;
    out_rdy = 1'b1;
    total = 0;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      send_beat(W'(i), 1'b0, c);
      total += c;
      w[(i % R)*W +: W] = W'(i);
      if (i % R == R - 1) exp_q.push_back({w, 4'b1111, 1'b0});
    end
    n_checks++;
    if (total != 16) begin
      n_fail++;
      $display("FAIL streaming_rate: got %0d cycles for 16 beats want 16", total);
    end
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL streaming_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL streaming: got %h/%b/%b want %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_single_beat();
    int c;
    word_t e, g;
    out_rdy = 1'b1;
    send_beat(8'h5A, 1'b1, c);
    exp_q.push_back({32'h0000005A, 4'b0001, 1'b1});
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_beat_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL single_beat: got %h/%b/%b want %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_async_reset();
    int c;
    word_t e, g;
    out_rdy = 1'b0;
    send_beat(8'hF1, 1'b0, c);
    send_beat(8'hF2, 1'b0, c);
    send_beat(8'hF3, 1'b0, c);
    send_beat(8'hF4, 1'b0, c);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_val !== 1'b0 || out_keep !== 4'b0000 || out_data !== 32'h0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_pending: got val=%b keep=%b data=%h last=%b want all zero",
               out_val, out_keep, out_data, out_last);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'hE1, 1'b0, c);
    send_beat(8'hE2, 1'b0, c);
    #2;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    send_beat(8'h01, 1'b0, c);
    send_beat(8'h02, 1'b0, c);
    send_beat(8'h03, 1'b0, c);
    send_beat(8'h04, 1'b0, c);
    exp_q.push_back({32'h04030201, 4'b1111, 1'b0});
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL async_reset_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL async_reset_clean: got %h/%b/%b want %h/%b/%b", g.data, g.keep, g.last, e.data, e.keep, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_last();
    test_backpressure();
    test_streaming();
    test_single_beat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_packer.md
Name: beat_packer

Overview:
- Width upsizer that sits directly downstream of the stream FIFO.
- Consumes WIDTH-bit beats over the valid/ready handshake and packs RATIO consecutive beats into one WIDTH*RATIO-bit output word.
- An in_last beat closes a frame early and emits a partial word; out_keep marks the valid lanes.
- Output is fully registered; it feeds the wide-bus consumer (DMA/packet writer).

Parameters:
WIDTH, 8, bit width of one input beat (one lane)
RATIO, 4, lanes per output word; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_val  input  1  input beat valid
in_data  input  WIDTH  input beat payload
in_last  input  1  beat is final of frame; qualified by in_val
in_rdy  output  1  packer can accept a beat this cycle
out_val  output  1  packed word valid
out_data  output  WIDTH*RATIO  packed word; lane k = bits [k*WIDTH +: WIDTH]
out_keep  output  RATIO  bit k set = lane k holds a real beat
out_last  output  1  word closes a frame
out_rdy  input  1  downstream accepts word this cycle

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release): out_val=0, out_data=0, out_keep=0, out_last=0, lane count=0, accumulator=0.
- State: accumulator (RATIO-1 lanes), lane count cnt (0..RATIO-1), output register (data/keep/last/val).
- Accept rule: in_rdy = !out_val | out_rdy. This is combinational and independent of in_val and in_last. An input beat is taken when in_val & in_rdy. An output word is taken when out_val & out_rdy.
- Lane order: first beat of a word goes to lane 0 (LSBs), nth beat to lane n.
- Non-completing accept (cnt < RATIO-1 and in_last=0): write the accumulator lane cnt, then cnt <= cnt+1. The output register is unchanged.
- Completing accept (cnt == RATIO-1, or in_last=1):
  - The output register loads the accumulator lanes 0..cnt-1 plus in_data in lane cnt.
  - Lanes above cnt load as zero.
  - out_keep = (1<<(cnt+1))-1; out_last = in_last; out_val <= 1.
  - Accumulator clears to 0 and cnt <= 0 in the same edge.
- Latency: the completing beat appears on out_* one cycle after its acceptance.
- Output hold: while out_val=1 and out_rdy=0, out_data/out_keep/out_last stay stable and in_rdy=0. No beats are accepted, even non-completing ones.
- Simultaneous drain and completion: when out_val=1, out_rdy=1 and a completing beat is accepted, the new word replaces the old one and out_val stays 1. This gives back-to-back words with no bubble.
- Drain without completion: out_val <= 0 after the word is taken.
- Sustained throughput: 1 beat/cycle in, 1 word per RATIO cycles out, with out_rdy held high.
- in_last on lane RATIO-1: a single full word with out_keep all ones and out_last=1.
- Frame boundaries: in_last always closes the word. The next beat starts at lane 0 of a new word, so frames never share a word.
- Idle: in_val=0 leaves cnt and the accumulator untouched indefinitely. There is no timeout flush.
- Reset mid-operation: a partial accumulator and any pending output word are discarded; all outputs return to their reset values immediately.
- cnt width is $clog2(RATIO). cnt never exceeds RATIO-1.

Test Plan:
- Full word (WIDTH=8, RATIO=4, out_rdy=1): beats 0x11,0x22,0x33,0x44, no last -> one cycle after the 4th accept, out_data=0x44332211, out_keep=4'b1111, out_last=0, out_val for exactly 1 cycle.
- Early last: beats 0xAA, 0xBB (last=1) -> out_data=0x0000BBAA, out_keep=4'b0011, out_last=1. A following beat 0xCC lands in lane 0 of the next word.
- Backpressure: complete word 0x04030201, hold out_rdy=0 for 5 cycles -> out_* stable, in_rdy=0 throughout, no beats lost. Release out_rdy -> word accepted, in_rdy=1 in that same cycle.
- Streaming: 16 back-to-back beats 0x00..0x0F with in_val=1 and out_rdy=1 -> 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; in_rdy never drops.
- Single-beat frame: beat 0x5A with last=1 when cnt=0 -> out_data=0x0000005A, out_keep=4'b0001, out_last=1.
- Async reset: after 2 beats accepted and with a pending word (out_rdy=0), pull reset low mid-cycle -> out_val=0, out_keep=0 immediately. After release, 4 beats produce a clean word with no stale lanes.
